// File: rtl/ivl_uvm_rd_arb_pkg.sv
// Shared types for the read-window arbiter.
// State encoding and id-width helper.
package ivl_uvm_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ivl_uvm_rr_picker.sv
// Combinational round-robin picker: first set
// request bit at or after ptr, wrapping around.
module ivl_uvm_rr_picker
  import ivl_uvm_rd_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_id,
  output logic          any
);

  logic [IW-1:0] sel;

  always_comb begin
    win    = '0;
    win_id = '0;
    any    = 1'b0;
    sel    = '0;
    for (int i = 0; i < N; i++) begin
      sel = IW'((int'(ptr) + i) % N);
      if (!any && req[sel]) begin
        any      = 1'b1;
        win[sel] = 1'b1;
        win_id   = sel;
      end
    end
  end

endmodule

// File: rtl/ivl_uvm_rd_win_arbiter.sv
// Round-robin owner of the single-entry read queue:
// one open rd/rd_ack window at a time, with timeout.
module ivl_uvm_rd_win_arbiter
  import ivl_uvm_rd_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 1,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IW = id_w(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rd,
  input  logic               rd_ack,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               win_active,
  output logic               rsp_valid,
  output logic               rsp_timeout,
  output logic [IW-1:0]      rsp_id,
  output logic [DATA_W-1:0]  rsp_data
);

  state_e              state, state_d;
  logic [IW-1:0]       ptr, ptr_d;
  logic [IW-1:0]       cur_id, cur_id_d;
  logic [CW-1:0]       cnt, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0]  gnt_d;
  logic                rd_d, win_d;
  logic                valid_d, tout_d;
  logic [IW-1:0]       rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_d;

  logic [NUM_REQ-1:0]  pick_win;
  logic [IW-1:0]       pick_id;
  logic                pick_any;

  ivl_uvm_rr_picker #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .win    (pick_win),
    .win_id (pick_id),
    .any    (pick_any)
  );

  // Saturating so a stuck WAIT can never wrap back below the limit.
  assign cnt_inc = (cnt == CW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    cur_id_d   = cur_id;
    cnt_d      = cnt;
    gnt_d      = gnt;
    rd_d       = 1'b0;
    win_d      = 1'b0;
    valid_d    = 1'b0;
    tout_d     = 1'b0;
    rsp_id_d   = rsp_id;
    rsp_data_d = rsp_data;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_d  = ISSUE;
          gnt_d    = pick_win;
          cur_id_d = pick_id;
          rd_d     = 1'b1;
          win_d    = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        win_d   = 1'b1;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (rd_ack) begin
          state_d    = RESP;
          valid_d    = 1'b1;
          rsp_id_d   = cur_id;
          rsp_data_d = rd_data;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          state_d  = RESP;
          tout_d   = 1'b1;
          rsp_id_d = cur_id;
        end else begin
          win_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (cur_id == IW'(NUM_REQ - 1)) ?
                  '0 : cur_id + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cur_id      <= '0;
      cnt         <= '0;
      gnt         <= '0;
      rd          <= 1'b0;
      win_active  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      cur_id      <= cur_id_d;
      cnt         <= cnt_d;
      gnt         <= gnt_d;
      rd          <= rd_d;
      win_active  <= win_d;
      rsp_valid   <= valid_d;
      rsp_timeout <= tout_d;
      rsp_id      <= rsp_id_d;
      rsp_data    <= rsp_data_d;
    end
  end

endmodule
